// File: rtl/aes_shiftrows_iter.sv
// rtl/aes_shiftrows_iter.sv - round-iterative ShiftRows/InvShiftRows engine with valid/ready handshake
module aes_shiftrows_iter #(
  parameter int NB = 4,
  parameter int W  = 32*NB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:W-1] in_data,
  input  logic         inverse,
  input  logic         single,
  input  logic [1:0]   key_size,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:W-1] out_data,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  // Row offsets exist only for 4..8 columns; W is derived from NB.
  if (NB < 4 || NB > 8) begin : g_bad_nb
    $error("aes_shiftrows_iter: NB must be in 4..8");
  end
  if (W != 32*NB) begin : g_bad_w
    $error("aes_shiftrows_iter: W must equal 32*NB");
  end

  // Row offsets C1..C3; row 0 never moves.
  localparam int C1 = 1;
  localparam int C2 = (NB == 8) ? 3 : 2;
  localparam int C3 = (NB >= 7) ? 4 : 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         inv_q;
  logic [3:0]   n_q;
  logic [3:0]   n_sel;
  logic [0:W-1] shifted;
  logic         accept;
  logic         last_round;

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state == S_RUN);
  assign out_valid  = (state == S_DONE);
  assign accept     = in_valid && in_ready;
  assign last_round = ((round_cnt + 4'd1) == n_q);

  // Number of shifts for the job being offered.
  always_comb begin
    n_sel = 4'd10;
    if (single) begin
      n_sel = 4'd1;
    end else begin
      case (key_size)
        2'b00:   n_sel = 4'd10;
        2'b01:   n_sel = 4'd12;
        default: n_sel = 4'd14;
      endcase
    end
  end

  // One forward or inverse row shift of the working register.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        int off;
        int src;
        off = (r == 0) ? 0 : (r == 1) ? C1 : (r == 2) ? C2 : C3;
        src = inv_q ? ((c - off + NB) % NB) : ((c + off) % NB);
        shifted[8*(4*c+r) +: 8] = out_data[8*(4*src+r) +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last_round) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Working register, latched mode and round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      inv_q     <= 1'b0;
      n_q       <= 4'd0;
      round_cnt <= 4'd0;
    end else begin
      if (accept) begin
        out_data  <= in_data;
        inv_q     <= inverse;
        n_q       <= n_sel;
        round_cnt <= 4'd0;
      end else if (state == S_RUN) begin
        out_data  <= shifted;
        round_cnt <= round_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_shiftrows_iter.sv
// tb/tb_aes_shiftrows_iter.sv - randomized self-checking bench for aes_shiftrows_iter (NB=4 and NB=8)
module tb_aes_shiftrows_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid4 = 1'b0, inverse4 = 1'b0, single4 = 1'b0, out_ready4 = 1'b0;
  logic [1:0]   key_size4 = 2'b00;
  logic [0:127] in_data4 = '0;
  logic         in_ready4, out_valid4, busy4;
  logic [0:127] out_data4;
  logic [3:0]   round_cnt4;

  logic         in_valid8 = 1'b0, inverse8 = 1'b0, single8 = 1'b0, out_ready8 = 1'b0;
  logic [1:0]   key_size8 = 2'b00;
  logic [0:255] in_data8 = '0;
  logic         in_ready8, out_valid8, busy8;
  logic [0:255] out_data8;
  logic [3:0]   round_cnt8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aes_shiftrows_iter #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .inverse(inverse4), .single(single4), .key_size(key_size4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .busy(busy4), .round_cnt(round_cnt4)
  );

  aes_shiftrows_iter #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .inverse(inverse8), .single(single8), .key_size(key_size8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .busy(busy8), .round_cnt(round_cnt8)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int row_offset(input int nb, input int r);
    if (r == 0) return 0;
    if (r == 1) return 1;
    if (r == 2) return (nb == 8) ? 3 : 2;
    return (nb >= 7) ? 4 : 3;
  endfunction

  function automatic int rounds_of(input bit sgl, input logic [1:0] ks);
    if (sgl) return 1;
    if (ks == 2'b00) return 10;
    if (ks == 2'b01) return 12;
    return 14;
  endfunction

  // n successive shifts of a row collapse to a single rotation by n*Cr mod nb.
  function automatic logic [0:255] ref_model(input int nb, input logic [0:255] a,
                                             input bit inv, input int n);
    logic [0:255] s;
    s = '0;
    for (int r = 0; r < 4; r++) begin
      int sh;
      sh = (n * row_offset(nb, r)) % nb;
      for (int c = 0; c < nb; c++) begin
        int src;
        src = inv ? ((c - sh + nb) % nb) : ((c + sh) % nb);
        s[8*(4*c+r) +: 8] = a[8*(4*src+r) +: 8];
      end
    end
    return s;
  endfunction

  function automatic logic [0:255] rand_blk();
    logic [0:255] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [0:255] seq_blk(input int nb);
    logic [0:255] b;
    b = '0;
    for (int k = 0; k < 4*nb; k++) b[8*k +: 8] = k[7:0];
    return b;
  endfunction

  // Full NB=4 job; scramble toggles mode inputs and in_valid during RUN, hold delays out_ready in DONE.
  task automatic run4(input string tag, input logic [0:255] d, input bit inv, input bit sgl,
                      input logic [1:0] ks, input bit scramble, input int hold);
    int n, lat;
    logic [0:255] exp;
    n   = rounds_of(sgl, ks);
    exp = ref_model(4, d, inv, n);
    in_data4 = d[0:127]; inverse4 = inv; single4 = sgl; key_size4 = ks; in_valid4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    check({tag, "/busy"}, busy4, 1);
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      if (scramble) begin
        inverse4 = $urandom_range(0, 1); single4 = $urandom_range(0, 1);
        key_size4 = $urandom_range(0, 3); in_valid4 = $urandom_range(0, 1);
        in_data4 = rand_blk()[0:127];
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    in_valid4 = 1'b0;
    check({tag, "/latency"}, lat, n);
    check({tag, "/data"}, out_data4, exp[0:127]);
    check({tag, "/round_cnt"}, round_cnt4, n);
    check({tag, "/in_ready_done"}, in_ready4, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid4 = i[0];
      @(posedge clk); @(negedge clk);
      check({tag, "/hold_valid"}, out_valid4, 1);
      check({tag, "/hold_in_ready"}, in_ready4, 0);
      check({tag, "/hold_data"}, out_data4, exp[0:127]);
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "/in_ready_after"}, in_ready4, 1);
    check({tag, "/out_valid_after"}, out_valid4, 0);
    check({tag, "/round_cnt_held"}, round_cnt4, n);
  endtask

  task automatic run8(input string tag, input logic [0:255] d, input bit inv, input bit sgl,
                      input logic [1:0] ks);
    int n, lat;
    logic [0:255] exp;
    n   = rounds_of(sgl, ks);
    exp = ref_model(8, d, inv, n);
    in_data8 = d; inverse8 = inv; single8 = sgl; key_size8 = ks; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({tag, "/latency"}, lat, n);
    check({tag, "/data"}, out_data8, exp);
    check({tag, "/round_cnt"}, round_cnt8, n);
    out_ready8 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, "/in_ready_after"}, in_ready8, 1);
  endtask

  initial begin
    logic [0:255] blk;
    int guard;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("reset/in_ready", in_ready4, 1);
    check("reset/out_valid", out_valid4, 0);
    check("reset/busy", busy4, 0);
    check("reset/round_cnt", round_cnt4, 0);
    check("reset/out_data", out_data4, 0);

    // Directed NB=4 vectors from the known-answer table.
    blk = seq_blk(4);
    run4("tp_fwd1", blk, 1'b0, 1'b1, 2'b00, 1'b0, 0);
    check("tp_fwd1/const", out_data4, 128'h00050a0f04090e03080d02070c01060b);
    blk = {128'h00050a0f04090e03080d02070c01060b, 128'h0};
    run4("tp_inv1", blk, 1'b1, 1'b1, 2'b00, 1'b0, 0);
    check("tp_inv1/const", out_data4, 128'h000102030405060708090a0b0c0d0e0f);
    blk = seq_blk(4);
    run4("tp_r10", blk, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    check("tp_r10/const", out_data4, 128'h0009020b040d060f08010a030c050e07);
    run4("tp_r12", blk, 1'b0, 1'b0, 2'b01, 1'b0, 0);
    check("tp_r12/const", out_data4, 128'h000102030405060708090a0b0c0d0e0f);
    run4("tp_r14", blk, 1'b0, 1'b0, 2'b11, 1'b0, 0);
    check("tp_r14/const", out_data4, 128'h0009020b040d060f08010a030c050e07);

    // Backpressure in DONE with ignored in_valid pulses.
    run4("backpressure", rand_blk(), 1'b1, 1'b0, 2'b10, 1'b0, 5);

    // Reset in the middle of a 14-round job.
    in_data4 = rand_blk()[0:127]; inverse4 = 1'b0; single4 = 1'b0; key_size4 = 2'b11;
    in_valid4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    guard = 0;
    while (round_cnt4 != 4'd5 && guard < 40) begin
      @(posedge clk); guard++; @(negedge clk);
    end
    check("midrst/reach5", round_cnt4, 5);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst/out_valid", out_valid4, 0);
    check("midrst/busy", busy4, 0);
    check("midrst/round_cnt", round_cnt4, 0);
    check("midrst/out_data", out_data4, 0);
    check("midrst/in_ready", in_ready4, 1);
    run4("after_rst", rand_blk(), 1'b0, 1'b0, 2'b01, 1'b0, 0);

    // Randomized NB=4 jobs with mode inputs churning during RUN.
    for (int i = 0; i < 24; i++) begin
      run4("rand4", rand_blk(), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), 1'b1, $urandom_range(0, 2));
    end

    // NB=8: offsets 1,3,4.
    blk = seq_blk(8);
    run8("nb8_fwd1", blk, 1'b0, 1'b1, 2'b00);
    check("nb8_fwd1/byte_r1c0", out_data8[8:15], 8'h05);
    check("nb8_fwd1/byte_r2c0", out_data8[16:23], 8'h0e);
    check("nb8_fwd1/byte_r3c0", out_data8[24:31], 8'h13);
    check("nb8_fwd1/byte_r1c7", out_data8[232:239], 8'h01);
    blk = out_data8;
    run8("nb8_inv1", blk, 1'b1, 1'b1, 2'b00);
    check("nb8_inv1/orig", out_data8, seq_blk(8));
    for (int i = 0; i < 6; i++) begin
      run8("rand8", rand_blk(), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
